// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter: round-robin arbiter of N core TCM channels onto one TCM port, one access in flight
// Define TCM_ARB_PERF_EN to build the per-core saturating stall counters on perf_stall_o.
module tcm_port_arbiter #(
    parameter int N_CORES    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDRW      = 10
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_CORES-1:0]              core_req_i,
    input  logic [N_CORES-1:0]              core_we_i,
    input  logic [N_CORES*DATA_WIDTH/8-1:0] core_be_i,
    input  logic [N_CORES*ADDRW-1:0]        core_addr_i,
    input  logic [N_CORES*DATA_WIDTH-1:0]   core_data_i,
    output logic [DATA_WIDTH-1:0]           core_data_o,
    output logic [N_CORES-1:0]              core_ready_o,
    output logic                            tcm_en_o,
    output logic                            tcm_we_o,
    output logic [DATA_WIDTH/8-1:0]         tcm_be_o,
    output logic [ADDRW-1:0]                tcm_addr_o,
    output logic [DATA_WIDTH-1:0]           tcm_data_o,
    input  logic [DATA_WIDTH-1:0]           tcm_data_i,
    input  logic                            tcm_ready_i,
    output logic [N_CORES*32-1:0]           perf_stall_o
);
    localparam int BW = DATA_WIDTH/8;
    localparam int GW = $clog2(N_CORES);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nxt;
    logic [GW-1:0] ptr, grant, winner;
    logic [GW:0] sum;
    logic found, done;
    logic we_q;
    logic [BW-1:0] be_q;
    logic [ADDRW-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    // descending scan so the requester closest at/after ptr overwrites the rest
    always_comb begin
        winner = ptr;
        found = 1'b0;
        sum = '0;
        for (int i = N_CORES-1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (GW+1)'(i);
            sum = sum >= (GW+1)'(N_CORES) ? sum - (GW+1)'(N_CORES) : sum;
            if (core_req_i[sum[GW-1:0]]) begin
                winner = sum[GW-1:0];
                found = 1'b1;
            end
        end
    end
    assign done = state == RESP && tcm_ready_i;
    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (found ? ACCESS : IDLE) :
                    state == ACCESS ? RESP :
                    done ? IDLE : state;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr <= '0;
            grant <= '0;
            we_q <= 1'b0;
            be_q <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                grant <= winner;
                we_q <= core_we_i[winner];
                be_q <= core_be_i[winner*BW +: BW];
                addr_q <= core_addr_i[winner*ADDRW +: ADDRW];
                data_q <= core_data_i[winner*DATA_WIDTH +: DATA_WIDTH];
            end
            if (done)
                ptr <= grant == GW'(N_CORES-1) ? '0 : grant + 1'b1;
        end
    end
    assign tcm_en_o = state == ACCESS;
    assign tcm_we_o = we_q;
    assign tcm_be_o = be_q;
    assign tcm_addr_o = addr_q;
    assign tcm_data_o = data_q;
    assign core_ready_o = done ? N_CORES'(1) << grant : '0;
    assign core_data_o = done ? tcm_data_i : '0;
`ifdef TCM_ARB_PERF_EN
    for (genvar g = 0; g < N_CORES; g++) begin : g_perf
        logic [31:0] cnt;
        always_ff @(posedge clk_i) begin
            if (rst_i)
                cnt <= '0;
            else if (core_req_i[g] && !core_ready_o[g] && cnt != 32'hFFFF_FFFF)
                cnt <= cnt + 32'd1;
        end
        assign perf_stall_o[g*32 +: 32] = cnt;
    end
`else
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_tcm_port_arbiter.sv
// tb_tcm_port_arbiter: directed and randomized check of tcm_port_arbiter against a transaction-level model
module tb_tcm_port_arbiter;
    localparam int N = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW/8;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_i;
    logic [N-1:0] core_req_i, core_we_i, core_ready_o;
    logic [N*BW-1:0] core_be_i;
    logic [N*AW-1:0] core_addr_i;
    logic [N*DW-1:0] core_data_i;
    logic [DW-1:0] core_data_o, tcm_data_o, tcm_data_i;
    logic tcm_en_o, tcm_we_o, tcm_ready_i;
    logic [BW-1:0] tcm_be_o;
    logic [AW-1:0] tcm_addr_o;
    logic [N*32-1:0] perf_stall_o;
    tcm_port_arbiter #(.N_CORES(N), .DATA_WIDTH(DW), .ADDRW(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_be_i(core_be_i), .core_addr_i(core_addr_i), .core_data_i(core_data_i),
        .core_data_o(core_data_o), .core_ready_o(core_ready_o), .tcm_en_o(tcm_en_o),
        .tcm_we_o(tcm_we_o), .tcm_be_o(tcm_be_o), .tcm_addr_o(tcm_addr_o),
        .tcm_data_o(tcm_data_o), .tcm_data_i(tcm_data_i), .tcm_ready_i(tcm_ready_i),
        .perf_stall_o(perf_stall_o)
    );
    int total = 0;
    int bad = 0;
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];
    // model: owner=-1 when no access is held; issued once its TCM cycle has gone out
    int m_owner = -1;
    bit m_issued = 0;
    int m_ptr = 0;
    bit m_we;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_rd;
    logic [31:0] m_perf [N];
    int pend = -1;
    logic [DW-1:0] pend_data;
    bit rand_env = 0;
    logic obs_en, obs_we;
    logic [BW-1:0] obs_be;
    logic [AW-1:0] obs_addr;
    logic [N-1:0] obs_rdy;
    logic [DW-1:0] obs_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // compare one cycle near the falling edge, advance model and TCM, then step to the next cycle
    task automatic cyc();
        bit exp_en;
        logic [N-1:0] exp_rdy;
        bit hit;
        int k;
        #4;
        exp_en = m_owner >= 0 && !m_issued;
        exp_rdy = (m_owner >= 0 && m_issued && tcm_ready_i) ? N'(1) << m_owner : '0;
        obs_en = tcm_en_o; obs_we = tcm_we_o; obs_be = tcm_be_o; obs_addr = tcm_addr_o;
        obs_rdy = core_ready_o; obs_data = core_data_o;
        chk("tcm_en", 64'(tcm_en_o), 64'(exp_en));
        if (exp_en) begin
            chk("tcm_we", 64'(tcm_we_o), 64'(m_we));
            chk("tcm_be", 64'(tcm_be_o), 64'(m_be));
            chk("tcm_addr", 64'(tcm_addr_o), 64'(m_addr));
            chk("tcm_wdata", 64'(tcm_data_o), 64'(m_data));
        end
        chk("core_ready", 64'(core_ready_o), 64'(exp_rdy));
        if (exp_rdy != 0 && !m_we) chk("core_rdata", 64'(core_data_o), 64'(m_rd));
`ifdef TCM_ARB_PERF_EN
        for (int c = 0; c < N; c++) chk("perf_stall", 64'(perf_stall_o[c*32 +: 32]), 64'(m_perf[c]));
        for (int c = 0; c < N; c++)
            if (rst_i) m_perf[c] = 0;
            else if (core_req_i[c] && !exp_rdy[c] && m_perf[c] != 32'hFFFF_FFFF) m_perf[c]++;
`else
        chk("perf_zero", 64'(perf_stall_o != 0), 64'(0));
`endif
        if (exp_en) begin
            m_rd = ref_mem[m_addr];
            if (m_we) ref_mem[m_addr] = merge(ref_mem[m_addr], m_data, m_be);
        end
        if (rst_i) begin
            m_owner = -1; m_issued = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            hit = 0;
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (!hit && core_req_i[k]) begin
                    hit = 1; m_owner = k; m_issued = 0; m_we = core_we_i[k];
                    m_be = core_be_i[k*BW +: BW]; m_addr = core_addr_i[k*AW +: AW];
                    m_data = core_data_i[k*DW +: DW];
                end
            end
        end else if (!m_issued) m_issued = 1;
        else if (tcm_ready_i) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
        if (tcm_en_o) begin
            pend_data = mem[tcm_addr_o];
            if (tcm_we_o) mem[tcm_addr_o] = merge(mem[tcm_addr_o], tcm_data_o, tcm_be_o);
            pend = rst_i ? -1 : (!rand_env ? 0 : ($urandom % 10 == 0) ? 12 : int'($urandom % 3));
        end else if (rst_i) pend = -1;
        @(posedge clk_i);
        #1;
        tcm_data_i = $urandom;
        tcm_ready_i = 1'b0;
        if (pend == 0) begin
            tcm_ready_i = 1'b1; tcm_data_i = pend_data; pend = -1;
        end else if (pend > 0) pend--;
        else tcm_ready_i = rand_env && ($urandom % 8 == 0);
    endtask

    task automatic set_cmd(input int k, input bit we, input logic [BW-1:0] be,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_we_i[k] = we; core_be_i[k*BW +: BW] = be;
        core_addr_i[k*AW +: AW] = a; core_data_i[k*DW +: DW] = d;
    endtask

    int order [8];
    int when [8];
    int n;
    logic [N-1:0] last_rdy;

    initial begin
        rst_i = 1; core_req_i = 0; core_we_i = 0; core_be_i = 0; core_addr_i = 0; core_data_i = 0;
        tcm_ready_i = 0; tcm_data_i = 0;
        for (int c = 0; c < N; c++) m_perf[c] = 0;
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h11223344; ref_mem[5] = 32'h11223344;
        @(posedge clk_i); #1;
        cyc();
        chk("rst_en", 64'(tcm_en_o), 0); chk("rst_we", 64'(tcm_we_o), 0);
        chk("rst_be", 64'(tcm_be_o), 0); chk("rst_addr", 64'(tcm_addr_o), 0);
        chk("rst_wdata", 64'(tcm_data_o), 0); chk("rst_ready", 64'(core_ready_o), 0);
        chk("rst_rdata", 64'(core_data_o), 0); chk("rst_perf", 64'(perf_stall_o != 0), 0);
        rst_i = 0;
        // single read by core0
        set_cmd(0, 0, 4'hF, 10'h004, 0); core_req_i = 4'b0001;
        cyc(); chk("t1_en_t", 64'(obs_en), 0);
        cyc(); chk("t1_en_t1", 64'(obs_en), 1); chk("t1_addr", 64'(obs_addr), 64'h4);
        cyc(); chk("t1_ready", 64'(obs_rdy), 64'b0001); chk("t1_data", 64'(obs_data), 64'hDEADBEEF);
        core_req_i = 0;
        // byte write by core2 then read-back
        set_cmd(2, 1, 4'b0010, 10'd5, 32'h0000AB00); core_req_i = 4'b0100;
        cyc(); cyc(); chk("t2_we", 64'(obs_we), 1); chk("t2_be", 64'(obs_be), 64'b0010);
        cyc(); chk("t2_ready", 64'(obs_rdy), 64'b0100);
        set_cmd(2, 0, 4'hF, 10'd5, 0);
        cyc(); cyc(); cyc(); chk("t2_readback", 64'(obs_data), 64'h1122AB44);
        core_req_i = 0;
        // stray TCM ready while idle
        cyc(); tcm_ready_i = 1; tcm_data_i = 32'h1234;
        cyc(); chk("stray_ready", 64'(obs_rdy), 0);
        // pointer wrap after core3
        set_cmd(3, 0, 4'hF, 10'd7, 0); core_req_i = 4'b1000;
        cyc(); cyc(); cyc(); chk("t4_core3", 64'(obs_rdy), 64'b1000);
        set_cmd(0, 0, 4'hF, 10'd8, 0); set_cmd(2, 0, 4'hF, 10'd9, 0); core_req_i = 4'b0101;
        cyc(); cyc(); chk("t4_first_addr", 64'(obs_addr), 64'd8);
        cyc(); chk("t4_first", 64'(obs_rdy), 64'b0001);
        core_req_i = 4'b0100;
        cyc(); cyc(); chk("t4_second_addr", 64'(obs_addr), 64'd9);
        cyc(); chk("t4_second", 64'(obs_rdy), 64'b0100);
        core_req_i = 0;
        // reset during ACCESS
        set_cmd(1, 0, 4'hF, 10'd10, 0); set_cmd(3, 0, 4'hF, 10'd11, 0); core_req_i = 4'b0010;
        cyc(); rst_i = 1;
        cyc(); chk("t5_en_in_access", 64'(obs_en), 1);
        rst_i = 0; core_req_i = 4'b1010;
        cyc(); chk("t5_en_after", 64'(obs_en), 0); chk("t5_no_ready", 64'(obs_rdy), 0);
        cyc(); chk("t5_from_core0", 64'(obs_addr), 64'd10);
        cyc(); chk("t5_ready1", 64'(obs_rdy), 64'b0010);
        core_req_i = 4'b1000;
        cyc(); cyc(); cyc(); chk("t5_ready3", 64'(obs_rdy), 64'b1000);
        core_req_i = 0;
        // all cores continuously from reset
        rst_i = 1; core_req_i = 4'b1111;
        cyc(); rst_i = 0; n = 0;
        for (int c = 0; c < 24; c++) begin
            cyc();
            for (int k = 0; k < N; k++)
                if (obs_rdy[k] && n < 8) begin
                    order[n] = k; when[n] = c; n++;
                end
        end
        chk("t3_count", 64'(n), 8);
        for (int j = 0; j < 8; j++) begin
            chk("t3_order", 64'(order[j]), 64'(j % 4));
            chk("t3_time", 64'(when[j]), 64'(2 + 3*j));
        end
        core_req_i = 0;
`ifdef TCM_ARB_PERF_EN
        rst_i = 1;
        cyc(); rst_i = 0; core_req_i = 4'b0011;
        cyc(); cyc(); cyc(); chk("t6_ready0", 64'(obs_rdy), 64'b0001);
        core_req_i = 4'b0010;
        cyc(); cyc(); cyc(); chk("t6_ready1", 64'(obs_rdy), 64'b0010);
        core_req_i = 0;
        cyc(); chk("t6_perf0", 64'(perf_stall_o[31:0]), 64'd2);
        chk("t6_perf1", 64'(perf_stall_o[63:32]), 64'd5);
`endif
        // randomized traffic
        rand_env = 1; last_rdy = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom % 80 == 0);
            for (int k = 0; k < N; k++) begin
                set_cmd(k, 1'($urandom), BW'($urandom), AW'($urandom % 16), $urandom);
                if (last_rdy[k]) core_req_i[k] = ($urandom % 4 == 0);
                else if (!core_req_i[k]) core_req_i[k] = ($urandom % 3 == 0);
            end
            cyc();
            last_rdy = obs_rdy;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
